udma_spim_xfer_sched: RTL

Transfer scheduler sitting in front of the SPI master uDMA TX and RX channel configuration ports. Software or the SPI command engine pushes transfer descriptors (L2 address, size, direction, data size) into a small queue. The block then issues them one at a time to the matching channel, pulsing the channel enable. It waits for the channel to accept the transfer and drain before issuing the next descriptor, and reports completions.

---
 rtl/udma_spim_xfer_sched.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/udma_spim_xfer_sched.sv
// udma_spim_xfer_sched: queues SPI master transfer descriptors and issues them one at a time to the uDMA TX/RX channel config ports
// Ports:
//   clk_i, rstn_i                  clock, asynchronous active-low reset
//   req_valid_i/req_ready_o        descriptor push handshake (ready = queue not full, registered)
//   req_addr_i/size_i/txrxn_i/ds_i descriptor fields (txrxn 1 = TX channel, 0 = RX channel)
//   flush_i                        drop all queued, not yet issued descriptors
//   cfg_{tx,rx}_startaddr/size/datasize_o, cfg_{tx,rx}_en_o   issued descriptor and one-cycle enable pulse
//   cfg_{tx,rx}_en_i/pending_i     channel status (free when both are low)
//   busy_o, level_o                FSM active or queue non-empty; queued descriptor count
//   done_o, done_cnt_o             completion pulse and wrapping completion count
//   err_o                          wait-for-enable timeout pulse
// Optional: define SPIM_SCHED_TIMEOUT_EN to abort a descriptor whose channel does not raise en_i within 255 cycles.
module udma_spim_xfer_sched #(
  parameter int L2_AWIDTH_NOAL = 12,
  parameter int TRANS_SIZE     = 16,
  parameter int DEPTH          = 4
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic [L2_AWIDTH_NOAL-1:0] req_addr_i,
  input  logic [TRANS_SIZE-1:0]     req_size_i,
  input  logic                      req_txrxn_i,
  input  logic [1:0]                req_ds_i,
  input  logic                      flush_i,
  output logic [L2_AWIDTH_NOAL-1:0] cfg_tx_startaddr_o,
  output logic [TRANS_SIZE-1:0]     cfg_tx_size_o,
  output logic [1:0]                cfg_tx_datasize_o,
  output logic                      cfg_tx_en_o,
  input  logic                      cfg_tx_en_i,
  input  logic                      cfg_tx_pending_i,
  output logic [L2_AWIDTH_NOAL-1:0] cfg_rx_startaddr_o,
  output logic [TRANS_SIZE-1:0]     cfg_rx_size_o,
  output logic [1:0]                cfg_rx_datasize_o,
  output logic                      cfg_rx_en_o,
  input  logic                      cfg_rx_en_i,
  input  logic                      cfg_rx_pending_i,
  output logic                      busy_o,
  output logic [$clog2(DEPTH):0]    level_o,
  output logic                      done_o,
  output logic [7:0]                done_cnt_o,
  output logic                      err_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int DW = L2_AWIDTH_NOAL + TRANS_SIZE + 3;
  typedef enum logic [1:0] {S_IDLE, S_WAIT_EN, S_WAIT_DONE} state_t;
  state_t                    state;
  logic [DW-1:0]             mem [DEPTH];
  logic [PW-1:0]             wr_ptr, rd_ptr;
  logic [CW-1:0]             count_nxt;
  logic [L2_AWIDTH_NOAL-1:0] head_addr;
  logic [TRANS_SIZE-1:0]     head_size;
  logic                      head_tx;
  logic [1:0]                head_ds;
  logic                      push, issue, fin, tmo, tgt, tgt_en, tgt_free, en_pulse, active_nxt, txrxn_q, err_q;
  assign {head_addr, head_size, head_tx, head_ds} = mem[rd_ptr];
  assign push = req_valid_i && req_ready_o;
  // While idle the head descriptor picks the channel; afterwards the latched in-flight direction does.
  assign tgt = (state == S_IDLE) ? head_tx : txrxn_q;
  assign tgt_en = tgt ? cfg_tx_en_i : cfg_rx_en_i;
  assign tgt_free = !tgt_en && !(tgt ? cfg_tx_pending_i : cfg_rx_pending_i);
  assign en_pulse = cfg_tx_en_o || cfg_rx_en_o;
  // No issue while done_o/err_o is high, so consecutive issues keep an idle cycle after completion.
  assign issue = (state == S_IDLE) && (level_o != '0) && tgt_free && !done_o && !err_q;
  assign fin = (state == S_WAIT_DONE) && tgt_free;
  assign active_nxt = issue || ((state != S_IDLE) && !fin && !tmo);
  assign count_nxt = flush_i ? '0 : level_o + CW'(push) - CW'(issue);
  assign err_o = err_q;
`ifdef SPIM_SCHED_TIMEOUT_EN
  logic [7:0] tmo_cnt;
  // Counter is 0 in the en_o pulse cycle; abort after 254 further cycles without en_i.
  assign tmo = (state == S_WAIT_EN) && !(tgt_en && !en_pulse) && (tmo_cnt == 8'd254);
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) tmo_cnt <= '0;
    else tmo_cnt <= issue ? '0 : (state == S_WAIT_EN) ? tmo_cnt + 8'd1 : tmo_cnt;
`else
  assign tmo = 1'b0;
`endif
  always_ff @(posedge clk_i)
    if (push && !flush_i) mem[wr_ptr] <= {req_addr_i, req_size_i, req_txrxn_i, req_ds_i};
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level_o     <= '0;
      req_ready_o <= 1'b1;
    end else begin
      level_o     <= count_nxt;
      req_ready_o <= count_nxt != CW'(DEPTH);
      wr_ptr      <= flush_i ? '0 : wr_ptr + PW'(push);
      rd_ptr      <= flush_i ? '0 : rd_ptr + PW'(issue);
    end
  end
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state              <= S_IDLE;
      txrxn_q            <= 1'b0;
      cfg_tx_startaddr_o <= '0;
      cfg_tx_size_o      <= '0;
      cfg_tx_datasize_o  <= 2'b10;
      cfg_tx_en_o        <= 1'b0;
      cfg_rx_startaddr_o <= '0;
      cfg_rx_size_o      <= '0;
      cfg_rx_datasize_o  <= 2'b10;
      cfg_rx_en_o        <= 1'b0;
      done_o             <= 1'b0;
      done_cnt_o         <= '0;
      err_q              <= 1'b0;
      busy_o             <= 1'b0;
    end else begin
      cfg_tx_en_o <= issue && head_tx;
      cfg_rx_en_o <= issue && !head_tx;
      done_o      <= fin;
      err_q       <= tmo;
      busy_o      <= active_nxt || (count_nxt != '0);
      if (fin) done_cnt_o <= done_cnt_o + 8'd1;
      if (issue) begin
        txrxn_q <= head_tx;
        if (head_tx) begin
          cfg_tx_startaddr_o <= head_addr;
          cfg_tx_size_o      <= head_size;
          cfg_tx_datasize_o  <= head_ds;
        end else begin
          cfg_rx_startaddr_o <= head_addr;
          cfg_rx_size_o      <= head_size;
          cfg_rx_datasize_o  <= head_ds;
        end
      end
      // en_i is ignored during the en_o pulse cycle itself.
      case (state)
        S_IDLE:      if (issue) state <= S_WAIT_EN;
        S_WAIT_EN:   if (tmo) state <= S_IDLE; else if (tgt_en && !en_pulse) state <= S_WAIT_DONE;
        S_WAIT_DONE: if (fin) state <= S_IDLE;
        default:     state <= S_IDLE;
      endcase
    end
  end
endmodule
